// File: rtl/int_alu_issue_pkg.sv
// int_alu_issue_pkg: shared packet type, latency constants and uop classification
package int_alu_issue_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int R_ADDR = 6;
  localparam int ROB_INDEX_BITS = 3;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 17;
  localparam logic [4:0] UOP_ADD = 5'h00;
  localparam logic [4:0] UOP_MUL = 5'h02;
  localparam logic [4:0] UOP_MULH = 5'h03;
  localparam logic [4:0] UOP_MULHSU = 5'h04;
  localparam logic [4:0] UOP_MULHU = 5'h05;
  localparam logic [4:0] UOP_DIV = 5'h06;
  localparam logic [4:0] UOP_DIVU = 5'h07;
  localparam logic [4:0] UOP_REM = 5'h08;
  localparam logic [4:0] UOP_REMU = 5'h09;
  typedef enum logic [1:0] {LAT_NORMAL, LAT_MUL, LAT_DIV} lat_class_t;
  typedef struct packed {
    logic [4:0] uop;
    logic [R_ADDR-1:0] rd;
    logic [ROB_INDEX_BITS-1:0] rob;
    logic [DATA_WIDTH-1:0] data1;
    logic [DATA_WIDTH-1:0] data2;
  } to_execution;
  function automatic lat_class_t classify_uop(to_execution p);
    logic ovf;
    // divide-by-zero and signed overflow are resolved combinationally by the FU
    ovf = (p.uop == UOP_DIV || p.uop == UOP_REM) && p.data1 == {1'b1, {(DATA_WIDTH-1){1'b0}}} && p.data2 == '1;
    if (p.uop >= UOP_MUL && p.uop <= UOP_MULHU) return LAT_MUL;
    if (p.uop >= UOP_DIV && p.uop <= UOP_REMU && p.data2 != '0 && !ovf) return LAT_DIV;
    return LAT_NORMAL;
  endfunction
endpackage

// File: rtl/int_alu_issue_if.sv
// int_alu_issue_if: dispatch-side and FU-side signals of the int ALU issue block
interface int_alu_issue_if import int_alu_issue_pkg::*; #(parameter int DEPTH = 4);
  logic in_valid, in_ready, flush, fu_busy, fu_valid;
  to_execution in_data, fu_data;
  logic [$clog2(DEPTH):0] q_count;
  modport master (output in_valid, in_data, flush, fu_busy, input in_ready, fu_valid, fu_data, q_count);
  modport slave (input in_valid, in_data, flush, fu_busy, output in_ready, fu_valid, fu_data, q_count);
endinterface

// File: rtl/int_issue_fifo.sv
// int_issue_fifo: circular packet buffer with push/pop/flush
module int_issue_fifo import int_alu_issue_pkg::*; #(parameter int DEPTH = 4) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  to_execution wdata,
  output to_execution rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  to_execution mem_q [DEPTH];
  to_execution mem_d [DEPTH];
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[tail_q] = wdata;
    head_d = flush ? '0 : head_q + AW'(pop);
    tail_d = flush ? '0 : tail_q + AW'(push);
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      mem_q <= mem_d;
    end
  end
  assign rdata = mem_q[head_q];
  assign count = count_q;
endmodule

// File: rtl/int_alu_issue.sv
// int_alu_issue: in-order issue to the int ALU with a writeback-slot scoreboard
module int_alu_issue import int_alu_issue_pkg::*; #(parameter int DEPTH = 4) (
  input  logic clk,
  input  logic rst_n,
  int_alu_issue_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = DIV_LAT + 1;
  localparam int LW = $clog2(SW);
  logic push, issue, in_ready;
  logic [CW-1:0] count;
  to_execution head_pkt;
  lat_class_t cls;
  logic [LW-1:0] lat;
  // bit k: ex_update is claimed k cycles from now; bit 0 is the current cycle
  logic [SW-1:0] wb_resv_q, wb_resv_d;
  logic [LW-1:0] div_cnt_q, div_cnt_d;
  int_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(issue), .flush(bus.flush),
    .wdata(bus.in_data), .rdata(head_pkt), .count(count)
  );
  always_comb begin
    cls = classify_uop(head_pkt);
    lat = cls == LAT_MUL ? LW'(MUL_LAT) : cls == LAT_DIV ? LW'(DIV_LAT) : '0;
    in_ready = count < CW'(DEPTH);
    push = bus.in_valid && in_ready && !bus.flush;
    issue = count != '0 && !bus.flush && !bus.fu_busy && !wb_resv_q[lat] && !(cls == LAT_DIV && div_cnt_q != '0);
    wb_resv_d = (wb_resv_q >> 1) | (issue && lat != '0 ? SW'(1) << (lat - 1'b1) : '0);
    // divider is occupied for the issue cycle plus DIV_LAT-1 further cycles
    div_cnt_d = issue && cls == LAT_DIV ? LW'(DIV_LAT - 1) : div_cnt_q - LW'(div_cnt_q != '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_resv_q <= '0;
      div_cnt_q <= '0;
    end else begin
      wb_resv_q <= wb_resv_d;
      div_cnt_q <= div_cnt_d;
    end
  end
  assign bus.in_ready = in_ready;
  assign bus.fu_valid = issue;
  assign bus.fu_data = count != '0 ? head_pkt : '0;
  assign bus.q_count = count;
  a_wb_slot_unique: assert property (@(posedge clk) disable iff (!rst_n) !(issue && wb_resv_q[lat]));
endmodule

// File: tb/tb_int_alu_issue.sv
// tb_int_alu_issue: directed-vector bench for int_alu_issue
module tb_int_alu_issue;
  import int_alu_issue_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int_alu_issue_if #(.DEPTH(4)) bus();
  int_alu_issue #(.DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic to_execution pk(input logic [4:0] u, input logic [31:0] a, input logic [31:0] b, input logic [2:0] r);
    pk = '{uop: u, rd: 6'(r) + 6'd8, rob: r, data1: a, data2: b};
  endfunction
  task automatic cyc(input logic v, input to_execution d, input logic fl, input logic bz);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data = d;
    bus.flush = fl;
    bus.fu_busy = bz;
    #1;
  endtask
  initial begin
    to_execution a, m, b1, b2, b3, d1, d2, x, z, r, o, mf, f1, f2, f3, f4, f5;
    to_execution p[5];
    a = pk(UOP_ADD, 32'd11, 32'd22, 3'd1);
    m = pk(UOP_MULH, 32'd3, 32'd4, 3'd2);
    b1 = pk(UOP_ADD, 32'd1, 32'd1, 3'd3);
    b2 = pk(UOP_ADD, 32'd2, 32'd2, 3'd4);
    b3 = pk(UOP_ADD, 32'd3, 32'd3, 3'd5);
    d1 = pk(UOP_DIV, 32'd100, 32'd7, 3'd3);
    d2 = pk(UOP_REM, 32'd50, 32'd7, 3'd4);
    x = pk(UOP_ADD, 32'd9, 32'd9, 3'd5);
    z = pk(UOP_REMU, 32'd5, 32'd0, 3'd5);
    r = pk(UOP_DIVU, 32'd9, 32'd3, 3'd6);
    o = pk(UOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 3'd7);
    mf = pk(UOP_MULHSU, 32'd6, 32'd7, 3'd0);
    f1 = pk(UOP_ADD, 32'd21, 32'd1, 3'd1);
    f2 = pk(UOP_ADD, 32'd22, 32'd2, 3'd2);
    f3 = pk(UOP_ADD, 32'd23, 32'd3, 3'd3);
    f4 = pk(UOP_ADD, 32'd24, 32'd4, 3'd4);
    f5 = pk(UOP_ADD, 32'd25, 32'd5, 3'd5);
    for (int i = 0; i < 5; i++) p[i] = pk(UOP_ADD, 32'(i * 3 + 1), 32'(i), 3'(i));
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_fu_valid", bus.fu_valid, 0);
    chk("rst_q_count", bus.q_count, 0);
    chk("rst_fu_data", bus.fu_data, 0);
    rst_n = 1'b1;
    // single ADD
    cyc(1'b1, a, 1'b0, 1'b0);
    chk("add_pre_valid", bus.fu_valid, 0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("add_valid", bus.fu_valid, 1);
    chk("add_data", bus.fu_data, a);
    chk("add_cnt", bus.q_count, 1);
    chk("add_ready", bus.in_ready, 1);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("add_cnt_after", bus.q_count, 0);
    chk("add_valid_after", bus.fu_valid, 0);
    // MUL then ADDs; the third ADD would retire on the MUL return cycle
    cyc(1'b1, m, 1'b0, 1'b0);
    cyc(1'b1, b1, 1'b0, 1'b0);
    chk("mul_valid", bus.fu_valid, 1);
    chk("mul_data", bus.fu_data, m);
    cyc(1'b1, b2, 1'b0, 1'b0);
    chk("mul_b1_valid", bus.fu_valid, 1);
    chk("mul_b1_data", bus.fu_data, b1);
    cyc(1'b1, b3, 1'b0, 1'b0);
    chk("mul_b2_valid", bus.fu_valid, 1);
    chk("mul_b2_data", bus.fu_data, b2);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("mul_b3_held", bus.fu_valid, 0);
    chk("mul_b3_cnt", bus.q_count, 1);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("mul_b3_valid", bus.fu_valid, 1);
    chk("mul_b3_data", bus.fu_data, b3);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("mul_cnt_after", bus.q_count, 0);
    // back-to-back DIVs with an ADD queued behind
    cyc(1'b1, d1, 1'b0, 1'b0);
    cyc(1'b1, d2, 1'b0, 1'b0);
    chk("div1_valid", bus.fu_valid, 1);
    chk("div1_data", bus.fu_data, d1);
    cyc(1'b1, x, 1'b0, 1'b0);
    chk("div2_blocked", bus.fu_valid, 0);
    chk("div2_cnt", bus.q_count, 1);
    for (int k = 3; k <= 17; k++) begin
      cyc(1'b0, '0, 1'b0, 1'b0);
      chk($sformatf("div_wait_c%0d", k), bus.fu_valid, 0);
    end
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("div2_valid", bus.fu_valid, 1);
    chk("div2_data", bus.fu_data, d2);
    chk("div2_qcnt", bus.q_count, 2);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("div_add_valid", bus.fu_valid, 1);
    chk("div_add_data", bus.fu_data, x);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("div_cnt_after", bus.q_count, 0);
    repeat (20) cyc(1'b0, '0, 1'b0, 1'b0);
    // divide-by-zero and signed overflow issue as NORMAL
    cyc(1'b1, z, 1'b0, 1'b0);
    cyc(1'b1, r, 1'b0, 1'b0);
    chk("dz_valid", bus.fu_valid, 1);
    chk("dz_data", bus.fu_data, z);
    cyc(1'b1, o, 1'b0, 1'b0);
    chk("dz_real_div_valid", bus.fu_valid, 1);
    chk("dz_real_div_data", bus.fu_data, r);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("ovf_valid", bus.fu_valid, 1);
    chk("ovf_data", bus.fu_data, o);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("dz_cnt_after", bus.q_count, 0);
    repeat (20) cyc(1'b0, '0, 1'b0, 1'b0);
    // fill while busy, overflow push ignored, drain in order across the wrap
    for (int i = 0; i < 4; i++) cyc(1'b1, p[i], 1'b0, 1'b1);
    cyc(1'b1, p[4], 1'b0, 1'b1);
    chk("full_ready", bus.in_ready, 0);
    chk("full_cnt", bus.q_count, 4);
    chk("full_busy_valid", bus.fu_valid, 0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("full_cnt_held", bus.q_count, 4);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc(1'b0, '0, 1'b0, 1'b0);
      chk($sformatf("drain%0d_valid", i), bus.fu_valid, 1);
      chk($sformatf("drain%0d_data", i), bus.fu_data, p[i]);
    end
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("drain_cnt_after", bus.q_count, 0);
    chk("drain_valid_after", bus.fu_valid, 0);
    // flush with 3 queued and a MUL in flight
    cyc(1'b1, mf, 1'b0, 1'b1);
    cyc(1'b1, f1, 1'b0, 1'b1);
    cyc(1'b1, f2, 1'b0, 1'b1);
    cyc(1'b1, f3, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("fl_mul_valid", bus.fu_valid, 1);
    chk("fl_mul_data", bus.fu_data, mf);
    cyc(1'b1, f4, 1'b1, 1'b0);
    chk("fl_no_issue", bus.fu_valid, 0);
    chk("fl_cnt_pre", bus.q_count, 3);
    cyc(1'b1, f5, 1'b0, 1'b0);
    chk("fl_cnt_post", bus.q_count, 0);
    chk("fl_valid_post", bus.fu_valid, 0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("fl_add_held", bus.fu_valid, 0);
    chk("fl_add_cnt", bus.q_count, 1);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("fl_add_valid", bus.fu_valid, 1);
    chk("fl_add_data", bus.fu_data, f5);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("fl_cnt_after", bus.q_count, 0);
    // asynchronous reset mid-operation
    cyc(1'b1, p[0], 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("ar_cnt_pre", bus.q_count, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_cnt", bus.q_count, 0);
    chk("ar_ready", bus.in_ready, 1);
    chk("ar_data", bus.fu_data, 0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b1, a, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("ar_post_valid", bus.fu_valid, 1);
    chk("ar_post_data", bus.fu_data, a);
    cyc(1'b0, '0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
